beta_prefetch_fetch_unit: RTL and testbench

- Parametrised successor of the single-request fetch unit.
- Keeps a private PC and issues pipelined, in-order instruction-memory requests, up to MaxOutstanding in flight.
- Buffers returned words in a FifoDepth-entry prefetch FIFO and hands them to the IF stage over a valid/ready interface.
- Supports PC redirect with flush and discard of stale responses; keeps hazard NOP injection and the penalty code on the IF-side output.

---
 rtl/beta_if_stage_pkg.sv | 29 ++
 rtl/beta_prefetch_fifo.sv | 61 ++++++
 rtl/beta_prefetch_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_beta_prefetch_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_if_stage_pkg.sv
// Shared types and constants for the IF-stage prefetch fetch unit.
// Optional feature macro used by the fetch unit: BETA_FU_PERF_CNT_EN.
package beta_if_stage_pkg;

  localparam int unsigned FU_STATE_W = 2;

  typedef enum logic [FU_STATE_W-1:0] {
    FU_IDLE  = 2'd0,
    FU_FETCH = 2'd1,
    FU_DRAIN = 2'd2
  } fu_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned PEN_CTRL_BIT = 0;
  localparam int unsigned PEN_TRAP_BIT = 1;
  localparam logic [1:0] PEN_NONE = 2'b00;
  localparam logic [1:0] PEN_CTRL = 2'b01;
  localparam logic [1:0] PEN_TRAP = 2'b10;

  function automatic logic [1:0] penality_code(input logic ctrl, input logic trap);
    logic [1:0] code;
    code = PEN_NONE;
    code[PEN_CTRL_BIT] = ctrl;
    code[PEN_TRAP_BIT] = trap;
    return code;
  endfunction

endpackage

// File: rtl/beta_prefetch_fifo.sv
// Synchronous FIFO of {pc, data} entries for the prefetch buffer.
// Depth must be a power of two so the pointers wrap naturally.
module beta_prefetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [Width-1:0]             wdata,
  output logic [Width-1:0]             rdata,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == CntW'(0));
  assign full    = (cnt == CntW'(Depth));
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= PtrW'(0);
      wr_ptr <= PtrW'(0);
      cnt    <= CntW'(0);
    end else if (flush) begin
      rd_ptr <= PtrW'(0);
      wr_ptr <= PtrW'(0);
      cnt    <= CntW'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/beta_prefetch_fetch_unit.sv
// Pipelined in-order instruction prefetcher with redirect/discard and hazard NOP injection.
// Define BETA_FU_PERF_CNT_EN to add saturating stall and discard counters.
module beta_prefetch_fetch_unit
  import beta_if_stage_pkg::*;
#(
  parameter int unsigned          DataWidth      = 32,
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          FifoDepth      = 4,
  parameter int unsigned          MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] BootAddr       = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_fu_fetch_en_i,
  input  logic                 if_fu_redirect_i,
  input  logic [AddrWidth-1:0] if_fu_redirect_pc_i,
  output logic                 if_fu_instr_req_o,
  output logic [AddrWidth-1:0] if_fu_instr_addr_o,
  input  logic                 if_fu_instr_ready_i,
  input  logic                 if_fu_instr_valid_i,
  input  logic [DataWidth-1:0] if_fu_instr_rdata_i,
  output logic [DataWidth-1:0] if_fu_instr_o,
  output logic [AddrWidth-1:0] if_fu_instr_pc_o,
  output logic                 if_fu_instr_valid_o,
  input  logic                 if_fu_if_ready_i,
  output logic                 if_fu_stage_busy_o,
  output logic [1:0]           if_fu_penality_o,
  input  logic                 if_fu_ctrl_hazard_flag_i,
  input  logic                 if_fu_trap_hazard_flag_i
`ifdef BETA_FU_PERF_CNT_EN
  ,
  output logic [31:0]          if_fu_stall_cnt_o,
  output logic [31:0]          if_fu_discard_cnt_o
`endif
);

  localparam int unsigned CntW   = $clog2(FifoDepth+1);
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned EntryW = AddrWidth + DataWidth;
  localparam logic [AddrWidth-1:0] PcStep = AddrWidth'(DataWidth/8);

  fu_state_t            state;
  fu_state_t            state_next;
  logic [AddrWidth-1:0] pc;
  logic [AddrWidth-1:0] resp_pc;
  logic [CntW-1:0]      outstanding;
  logic [CntW-1:0]      outstanding_next;
  logic [CntW-1:0]      discard;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [EntryW-1:0]    fifo_head;
  logic                 issue;
  logic                 accept;
  logic                 resp;
  logic                 push;
  logic                 pop;

  assign resp   = if_fu_instr_valid_i;
  assign issue  = (state == FU_FETCH) && if_fu_fetch_en_i
                  && ((SumW'(outstanding) + SumW'(fifo_count)) < SumW'(FifoDepth))
                  && (outstanding < CntW'(MaxOutstanding));
  assign accept = issue & if_fu_instr_ready_i;
  assign outstanding_next = outstanding + CntW'(accept) - CntW'(resp);

  // Responses land in order, so a kept response's PC is a running counter reset on redirect.
  assign push = resp && (discard == CntW'(0)) && !if_fu_redirect_i && !fifo_full;
  assign pop  = !fifo_empty && if_fu_if_ready_i && !if_fu_redirect_i;

  beta_prefetch_fifo #(
    .Depth (FifoDepth),
    .Width (EntryW)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (if_fu_redirect_i),
    .wdata ({resp_pc, if_fu_instr_rdata_i}),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FU_IDLE: begin
        if (if_fu_fetch_en_i) state_next = FU_FETCH;
        else                  state_next = FU_IDLE;
      end
      FU_FETCH: begin
        if (if_fu_fetch_en_i)                    state_next = FU_FETCH;
        else if (outstanding != CntW'(0))        state_next = FU_DRAIN;
        else                                     state_next = FU_IDLE;
      end
      FU_DRAIN: begin
        if (if_fu_fetch_en_i)                    state_next = FU_FETCH;
        else if (outstanding == CntW'(0))        state_next = FU_IDLE;
        else                                     state_next = FU_DRAIN;
      end
      default: state_next = FU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= FU_IDLE;
      pc          <= BootAddr;
      resp_pc     <= BootAddr;
      outstanding <= CntW'(0);
      discard     <= CntW'(0);
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (if_fu_redirect_i) begin
        // Every request still in flight after this edge belongs to the old stream.
        pc      <= if_fu_redirect_pc_i;
        resp_pc <= if_fu_redirect_pc_i;
        discard <= outstanding_next;
      end else begin
        if (accept) pc <= pc + PcStep;
        if (push)   resp_pc <= resp_pc + PcStep;
        if (resp && (discard != CntW'(0))) discard <= discard - CntW'(1);
      end
    end
  end

  assign if_fu_instr_req_o   = issue;
  assign if_fu_instr_addr_o  = pc;
  assign if_fu_instr_valid_o = !fifo_empty;
  assign if_fu_instr_pc_o    = fifo_head[EntryW-1:DataWidth];
  assign if_fu_stage_busy_o  = issue | (outstanding != CntW'(0));
  assign if_fu_penality_o    = penality_code(if_fu_ctrl_hazard_flag_i, if_fu_trap_hazard_flag_i);
  assign if_fu_instr_o       = (if_fu_ctrl_hazard_flag_i || if_fu_trap_hazard_flag_i || fifo_empty)
                               ? DataWidth'(NOP_INSTR) : fifo_head[DataWidth-1:0];

`ifdef BETA_FU_PERF_CNT_EN
  logic        drop;
  logic [31:0] stall_cnt;
  logic [31:0] discard_cnt;

  assign drop = resp && (if_fu_redirect_i || (discard != CntW'(0)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt   <= 32'd0;
      discard_cnt <= 32'd0;
    end else begin
      if ((state == FU_FETCH) && fifo_empty && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (drop && (discard_cnt != 32'hFFFF_FFFF))
        discard_cnt <= discard_cnt + 32'd1;
    end
  end

  assign if_fu_stall_cnt_o   = stall_cnt;
  assign if_fu_discard_cnt_o = discard_cnt;
`endif

endmodule

// File: tb/tb_beta_prefetch_fetch_unit.sv
// Randomized bench for beta_prefetch_fetch_unit with a queue-based reference model
// and a behavioural in-order imem with random latency.
module tb_beta_prefetch_fetch_unit;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          req;
  logic [AW-1:0] addr;
  logic          imem_ready;
  logic          imem_valid;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          if_ready;
  logic          busy;
  logic [1:0]    penality;
  logic          ctrl_haz;
  logic          trap_haz;
`ifdef BETA_FU_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   discard_cnt;
`endif

  beta_prefetch_fetch_unit #(
    .DataWidth      (DW),
    .AddrWidth      (AW),
    .FifoDepth      (DEPTH),
    .MaxOutstanding (MAXO),
    .BootAddr       (BOOT)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst),
    .if_fu_fetch_en_i         (fetch_en),
    .if_fu_redirect_i         (redirect),
    .if_fu_redirect_pc_i      (redirect_pc),
    .if_fu_instr_req_o        (req),
    .if_fu_instr_addr_o       (addr),
    .if_fu_instr_ready_i      (imem_ready),
    .if_fu_instr_valid_i      (imem_valid),
    .if_fu_instr_rdata_i      (imem_rdata),
    .if_fu_instr_o            (instr),
    .if_fu_instr_pc_o         (instr_pc),
    .if_fu_instr_valid_o      (instr_valid),
    .if_fu_if_ready_i         (if_ready),
    .if_fu_stage_busy_o       (busy),
    .if_fu_penality_o         (penality),
    .if_fu_ctrl_hazard_flag_i (ctrl_haz),
    .if_fu_trap_hazard_flag_i (trap_haz)
`ifdef BETA_FU_PERF_CNT_EN
    ,
    .if_fu_stall_cnt_o        (stall_cnt),
    .if_fu_discard_cnt_o      (discard_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model: delivered-word queue, in-flight count, pending discards, PC, fetch mode.
  entry_t      mq[$];
  int          mout;
  int          mdisc;
  int          mstate;      // 0 idle, 1 fetching, 2 draining
  logic [31:0] mpc;
  logic [31:0] im_addr[$];
  int          im_due[$];
  int          cyc;

  int p_en, p_ready, p_resp, p_ifr, p_redir, p_haz, max_lat;
  int n_checks;
  int n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hC0DE_0001;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    im_addr.delete();
    im_due.delete();
    mout   = 0;
    mdisc  = 0;
    mstate = 0;
    mpc    = BOOT;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req"},   req,         64'd0);
    check_val({tag, "_addr"},  addr,        BOOT);
    check_val({tag, "_valid"}, instr_valid, 64'd0);
    check_val({tag, "_busy"},  busy,        64'd0);
    check_val({tag, "_instr"}, instr,       NOP);
    check_val({tag, "_pen"},   penality,    64'd0);
  endtask

  task automatic set_knobs(input int en, input int rdy, input int rsp, input int ifr,
                           input int rdr, input int hz, input int lat);
    p_en = en; p_ready = rdy; p_resp = rsp; p_ifr = ifr; p_redir = rdr; p_haz = hz; max_lat = lat;
  endtask

  task automatic step(input logic force_redir, input logic [31:0] force_pc);
    logic        exp_req;
    logic        acc;
    logic        resp;
    logic [31:0] raddr;
    int          nout;
    entry_t      e;
    @(negedge clk);
    fetch_en    = ($urandom_range(99) < p_en);
    imem_ready  = ($urandom_range(99) < p_ready);
    if_ready    = ($urandom_range(99) < p_ifr);
    redirect    = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc = force_redir ? force_pc : (32'($urandom_range(1023)) << 2);
    ctrl_haz    = ($urandom_range(99) < p_haz);
    trap_haz    = ($urandom_range(99) < p_haz);
    resp        = (im_addr.size() != 0) && (im_due[0] <= cyc) && ($urandom_range(99) < p_resp);
    imem_valid  = resp;
    imem_rdata  = resp ? mem_word(im_addr[0]) : 32'hDEAD_BEEF;
    #1;
    exp_req = (mstate == 1) && fetch_en && (mout + mq.size() < DEPTH) && (mout < MAXO);
    check_val("req", req, exp_req);
    if (exp_req) check_val("addr", addr, mpc);
    check_val("valid", instr_valid, mq.size() != 0);
    if (mq.size() != 0) check_val("pc_out", instr_pc, mq[0].pc);
    if (ctrl_haz || trap_haz) check_val("instr_nop", instr, NOP);
    else if (mq.size() != 0)  check_val("instr", instr, mq[0].data);
    check_val("penality", penality, {trap_haz, ctrl_haz});
    check_val("busy", busy, exp_req || (mout != 0));

    acc = exp_req && imem_ready;
    raddr = 32'h0;
    if (resp) begin
      raddr = im_addr.pop_front();
      void'(im_due.pop_front());
    end
    if (acc) begin
      im_addr.push_back(mpc);
      im_due.push_back(cyc + 1 + $urandom_range(max_lat));
    end
    nout = mout + int'(acc) - int'(resp);
    if (redirect) begin
      mq.delete();
      mpc   = redirect_pc;
      mdisc = nout;
    end else begin
      if ((mq.size() != 0) && if_ready) void'(mq.pop_front());
      if (resp) begin
        if (mdisc > 0) mdisc--;
        else begin
          e.pc   = raddr;
          e.data = mem_word(raddr);
          mq.push_back(e);
        end
      end
      if (acc) mpc = mpc + 32'd4;
    end
    case (mstate)
      0:       if (fetch_en) mstate = 1;
      1:       if (!fetch_en) mstate = (mout > 0) ? 2 : 0;
      2:       if (fetch_en) mstate = 1; else if (mout == 0) mstate = 0;
      default: mstate = 0;
    endcase
    mout = nout;
    cyc++;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    ctrl_haz = 1'b0; trap_haz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    // Zero-wait imem, IF always ready: sequential stream.
    set_knobs(100, 100, 100, 100, 0, 0, 0);
    repeat (40) step(1'b0, 32'h0);

    // IF stalled: buffer fills, requests stop, then drain in order.
    set_knobs(100, 100, 100, 0, 0, 0, 0);
    repeat (20) step(1'b0, 32'h0);
    set_knobs(100, 100, 100, 100, 0, 0, 0);
    repeat (20) step(1'b0, 32'h0);

    // Redirect to 0x100 with two requests in flight.
    set_knobs(100, 100, 0, 100, 0, 0, 0);
    for (int i = 0; i < 20 && mout < MAXO; i++) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    set_knobs(100, 100, 100, 100, 0, 0, 0);
    repeat (20) step(1'b0, 32'h0);

    // Redirect in steady state: accept and response coincide with it.
    step(1'b1, 32'h0000_0200);
    repeat (20) step(1'b0, 32'h0);

    // Hazard flags while words are buffered.
    set_knobs(100, 100, 100, 30, 0, 50, 1);
    repeat (60) step(1'b0, 32'h0);

    // Fully random traffic including fetch-enable toggling.
    set_knobs(80, 70, 60, 70, 8, 15, 3);
    repeat (3000) step(1'b0, 32'h0);

    // Reset in the middle of a burst.
    set_knobs(100, 100, 0, 100, 0, 0, 0);
    for (int i = 0; i < 20 && mout < MAXO; i++) step(1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; imem_valid = 1'b0;
    ctrl_haz = 1'b0; trap_haz = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_knobs(100, 100, 100, 100, 0, 0, 2);
    repeat (40) step(1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
